calc1_arb: RTL and testbench

CALC1_ARB -- requirements
Module: calc1_arb

---
 rtl/calc1_arb.sv | 237 +++++++++++++++++++++++
 tb/tb_calc1_arb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc1_arb.sv
// calc1_arb: four requesters share one multi-cycle ALU through a round-robin arbiter.
// Define CALC1_ARB_TIMEOUT_EN to end a stalled ALU operation with an error response.
module calc1_arb #(
  parameter int DATA_W = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [1:0]        out_resp1,
  output logic [1:0]        out_resp2,
  output logic [1:0]        out_resp3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4,
  output logic [3:0]        alu_cmd_out,
  output logic [DATA_W-1:0] alu_op1_out,
  output logic [DATA_W-1:0] alu_op2_out,
  output logic              alu_start_out,
  input  logic              alu_done_in,
  input  logic [1:0]        alu_resp_in,
  input  logic [DATA_W-1:0] alu_data_in
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  logic [3:0]        cmd_in  [4];
  logic [DATA_W-1:0] data_in [4];

  logic [3:0]        cap_q, cap_d;
  logic [3:0]        pend_q, pend_d;
  logic [3:0]        inv_q, inv_d;
  logic [3:0]        cmd_q   [4];
  logic [DATA_W-1:0] op1_q   [4];
  logic [DATA_W-1:0] op2_q   [4];
  logic [1:0]        resp_q  [4];
  logic [1:0]        resp_d  [4];
  logic [DATA_W-1:0] odata_q [4];
  logic [DATA_W-1:0] odata_d [4];

  state_t            state_q;
  logic [1:0]        rr_q;
  logic [1:0]        gnt_q;
  logic              alu_start_q;
  logic [3:0]        alu_cmd_q;
  logic [DATA_W-1:0] alu_op1_q;
  logic [DATA_W-1:0] alu_op2_q;

  logic              fin;
  logic [1:0]        fin_resp;
  logic [DATA_W-1:0] fin_data;
  logic              win_vld;
  logic [1:0]        win_idx;

`ifdef CALC1_ARB_TIMEOUT_EN
  logic [3:0]        to_cnt_q;
`endif

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data1 = odata_q[0];
  assign out_data2 = odata_q[1];
  assign out_data3 = odata_q[2];
  assign out_data4 = odata_q[3];

  assign alu_cmd_out   = alu_cmd_q;
  assign alu_op1_out   = alu_op1_q;
  assign alu_op2_out   = alu_op2_q;
  assign alu_start_out = alu_start_q;

  function automatic logic cmd_valid(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  // Any ALU status other than ok is reported as an error with the result suppressed.
  function automatic logic [DATA_W+1:0] map_alu(input logic [1:0] r, input logic [DATA_W-1:0] d);
    if (r == 2'd1) return {2'd1, d};
    return {2'd2, {DATA_W{1'b0}}};
  endfunction

  // Round-robin pick: scanning from the highest offset down leaves the nearest pending port.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_q;
    for (int k = 3; k >= 0; k--) begin
      if (pend_q[rr_q + 2'(k)]) begin
        win_vld = 1'b1;
        win_idx = rr_q + 2'(k);
      end
    end
  end

  always_comb begin
    fin      = 1'b0;
    fin_resp = 2'd0;
    fin_data = '0;
    if (state_q == WAIT) begin
      if (alu_done_in) begin
        fin                  = 1'b1;
        {fin_resp, fin_data} = map_alu(alu_resp_in, alu_data_in);
      end
`ifdef CALC1_ARB_TIMEOUT_EN
      else if (to_cnt_q == 4'hF) begin
        fin      = 1'b1;
        fin_resp = 2'd2;
      end
`endif
    end
  end

  // Per-port capture: cycle 1 takes cmd/op1, cycle 2 takes op2 and either pends or flags invalid.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      cap_d[n]   = cap_q[n];
      pend_d[n]  = pend_q[n];
      inv_d[n]   = 1'b0;
      resp_d[n]  = 2'd0;
      odata_d[n] = '0;
      if (cap_q[n]) begin
        cap_d[n] = 1'b0;
        if (cmd_valid(cmd_q[n])) pend_d[n] = 1'b1;
        else                     inv_d[n]  = 1'b1;
      end else if ((cmd_in[n] != 4'd0) && !pend_q[n]) begin
        cap_d[n] = 1'b1;
      end
      if (inv_q[n]) resp_d[n] = 2'd2;
      if (fin && (gnt_q == 2'(n))) begin
        pend_d[n]  = 1'b0;
        resp_d[n]  = fin_resp;
        odata_d[n] = fin_data;
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cap_q  <= '0;
      pend_q <= '0;
      inv_q  <= '0;
      for (int n = 0; n < 4; n++) begin
        resp_q[n]  <= 2'd0;
        odata_q[n] <= '0;
      end
    end else begin
      cap_q  <= cap_d;
      pend_q <= pend_d;
      inv_q  <= inv_d;
      for (int n = 0; n < 4; n++) begin
        resp_q[n]  <= resp_d[n];
        odata_q[n] <= odata_d[n];
      end
    end
  end

  // Operand storage is gated by the control flags, so it needs no reset.
  always_ff @(posedge c_clk) begin
    for (int n = 0; n < 4; n++) begin
      if (cap_d[n] && !cap_q[n]) begin
        cmd_q[n] <= cmd_in[n];
        op1_q[n] <= data_in[n];
      end
      if (cap_q[n]) op2_q[n] <= data_in[n];
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_q        <= 2'd0;
      gnt_q       <= 2'd0;
      alu_start_q <= 1'b0;
      alu_cmd_q   <= 4'd0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
`ifdef CALC1_ARB_TIMEOUT_EN
      to_cnt_q    <= 4'd0;
`endif
    end else begin
      alu_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q     <= ISSUE;
            gnt_q       <= win_idx;
            rr_q        <= win_idx + 2'd1;
            alu_start_q <= 1'b1;
            alu_cmd_q   <= cmd_q[win_idx];
            alu_op1_q   <= op1_q[win_idx];
            alu_op2_q   <= op2_q[win_idx];
          end
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef CALC1_ARB_TIMEOUT_EN
          to_cnt_q <= 4'd0;
`endif
        end
        WAIT: begin
          if (fin) begin
            state_q <= RESP;
          end
`ifdef CALC1_ARB_TIMEOUT_EN
          else begin
            to_cnt_q <= to_cnt_q + 4'd1;
          end
`endif
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc1_arb.sv
// Self-checking bench for calc1_arb: vector table, scoreboard of expected responses, ALU model.
`timescale 1ns/1ps
module tb_calc1_arb;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [3:0]  req_cmd  [4];
  logic [31:0] req_data [4];
  logic [1:0]  oresp    [4];
  logic [31:0] odata    [4];
  logic [3:0]  alu_cmd_out;
  logic [31:0] alu_op1_out, alu_op2_out;
  logic        alu_start_out;
  logic        alu_done_in;
  logic [1:0]  alu_resp_in;
  logic [31:0] alu_data_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  calc1_arb dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(req_cmd[0]), .req2_cmd_in(req_cmd[1]),
    .req3_cmd_in(req_cmd[2]), .req4_cmd_in(req_cmd[3]),
    .req1_data_in(req_data[0]), .req2_data_in(req_data[1]),
    .req3_data_in(req_data[2]), .req4_data_in(req_data[3]),
    .out_resp1(oresp[0]), .out_resp2(oresp[1]), .out_resp3(oresp[2]), .out_resp4(oresp[3]),
    .out_data1(odata[0]), .out_data2(odata[1]), .out_data3(odata[2]), .out_data4(odata[3]),
    .alu_cmd_out(alu_cmd_out), .alu_op1_out(alu_op1_out), .alu_op2_out(alu_op2_out),
    .alu_start_out(alu_start_out), .alu_done_in(alu_done_in),
    .alu_resp_in(alu_resp_in), .alu_data_in(alu_data_in)
  );

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  int resp_seen = 0;

  // Response monitor: every nonzero response must match the oldest expectation.
  initial begin
    forever begin
      exp_t e;
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        if (oresp[p] != 2'd0) begin
          resp_seen++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp port%0d resp=%0d data=%h cyc=%0d, required no response",
                     p + 1, oresp[p], odata[p], cyc);
          end else begin
            e = sb.pop_front();
            if (e.port != p + 1 || e.resp != oresp[p] || e.data != odata[p] ||
                (e.cyc >= 0 && e.cyc != cyc)) begin
              errors++;
              $display("FAIL resp_sb got port%0d resp=%0d data=%h cyc=%0d required port%0d resp=%0d data=%h cyc=%0d",
                       p + 1, oresp[p], odata[p], cyc, e.port, e.resp, e.data, e.cyc);
            end
          end
        end
      end
    end
  end

  // ALU model
  bit          alu_hang = 1'b0;
  bit          alu_err  = 1'b0;
  int          alu_lat  = 2;
  bit          chk_ops  = 1'b0;
  logic [3:0]  exp_cmd;
  logic [31:0] exp_op1, exp_op2;
  int          start_cnt = 0;
  int          done_cnt = 0;
  int          poke_req = 0;
  int          poke_ack = 0;
  logic [1:0]  m_resp;
  logic [31:0] m_data, m_r;

  initial begin
    alu_done_in = 1'b0;
    alu_resp_in = 2'd0;
    alu_data_in = 32'd0;
    forever begin
      @(negedge c_clk);
      alu_done_in = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          alu_done_in = 1'b1;
          alu_resp_in = m_resp;
          alu_data_in = m_data;
        end
      end
      if (poke_req != poke_ack) begin
        poke_ack    = poke_req;
        alu_done_in = 1'b1;
        alu_resp_in = 2'd1;
        alu_data_in = 32'h1234;
      end
      if (alu_start_out) begin
        start_cnt++;
        if (chk_ops) begin
          checks++;
          if (alu_cmd_out != exp_cmd || alu_op1_out != exp_op1 || alu_op2_out != exp_op2) begin
            errors++;
            $display("FAIL alu_ops got cmd=%0d op1=%h op2=%h required cmd=%0d op1=%h op2=%h",
                     alu_cmd_out, alu_op1_out, alu_op2_out, exp_cmd, exp_op1, exp_op2);
          end
        end
        m_resp = 2'd1;
        case (alu_cmd_out)
          4'd1:    m_r = alu_op1_out + alu_op2_out;
          4'd2:    m_r = alu_op1_out - alu_op2_out;
          4'd5:    m_r = alu_op1_out << alu_op2_out[4:0];
          4'd6:    m_r = alu_op1_out >> alu_op2_out[4:0];
          default: begin m_r = 32'hBAD0BAD0; m_resp = 2'd2; end
        endcase
        if (alu_err) begin
          m_resp = 2'd2;
          m_data = 32'hDEAD;
        end else begin
          m_data = m_r;
        end
        if (!alu_hang) done_cnt = alu_lat - 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic push(input int port, input logic [1:0] r, input logic [31:0] d, input int c);
    exp_t e;
    e.port = port; e.resp = r; e.data = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] mask, input logic [3:0][3:0] cmds,
                       input logic [3:0][31:0] a, input logic [3:0][31:0] b, output int c0);
    @(negedge c_clk);
    c0 = cyc;
    for (int p = 0; p < 4; p++) if (mask[p]) begin req_cmd[p] = cmds[p]; req_data[p] = a[p]; end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) if (mask[p]) begin req_cmd[p] = 4'd0; req_data[p] = b[p]; end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) if (mask[p]) req_data[p] = 32'd0;
  endtask

  task automatic single(input int port, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, output int c0);
    logic [3:0][3:0]  cv;
    logic [3:0][31:0] av, bv;
    logic [3:0]       m;
    cv = '0; av = '0; bv = '0; m = '0;
    m[port-1] = 1'b1; cv[port-1] = cmd; av[port-1] = a; bv[port-1] = b;
    drive(m, cv, av, bv, c0);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge c_clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain outstanding=%0d required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    bit          err;
    logic [1:0]  xr;
    logic [31:0] xd;
    int          xstart;
  } vec_t;
  vec_t vt[8];

  logic [3:0][3:0]  cv;
  logic [3:0][31:0] av, bv;
  int c0, c1, sc, rs;

  initial begin
    vt[0] = '{1, 4'd1,  32'h1,        32'h1FFFFFFF, 1'b0, 2'd1, 32'h20000000, 1};
    vt[1] = '{2, 4'd2,  32'd10,       32'd3,        1'b0, 2'd1, 32'd7,        1};
    vt[2] = '{3, 4'd5,  32'h1,        32'd4,        1'b0, 2'd1, 32'h10,       1};
    vt[3] = '{4, 4'd6,  32'h80000000, 32'd31,       1'b0, 2'd1, 32'h1,        1};
    vt[4] = '{2, 4'd3,  32'h1,        32'h0,        1'b0, 2'd2, 32'h0,        0};
    vt[5] = '{1, 4'd15, 32'h77,       32'h88,       1'b0, 2'd2, 32'h0,        0};
    vt[6] = '{4, 4'd2,  32'd1,        32'd15,       1'b1, 2'd2, 32'h0,        1};
    vt[7] = '{3, 4'd1,  32'hFFFFFFFF, 32'd1,        1'b0, 2'd1, 32'h0,        1};

    for (int p = 0; p < 4; p++) begin req_cmd[p] = 4'd0; req_data[p] = 32'd0; end
    reset = 1'b0;
    repeat (2) @(negedge c_clk);
    #1;
    chk("rst_resp", {oresp[0], oresp[1], oresp[2], oresp[3]}, 64'd0);
    chk("rst_data", odata[0] | odata[1] | odata[2] | odata[3], 64'd0);
    chk("rst_alu", {alu_start_out, alu_cmd_out, alu_op1_out | alu_op2_out}, 64'd0);
    @(negedge c_clk);
    reset = 1'b1;

    // Four simultaneous requests after reset: granted 1,2,3,4; a repeat on pending port 4 is dropped.
    alu_lat = 2;
    for (int p = 0; p < 4; p++) begin cv[p] = 4'd1; av[p] = 32'(p + 1); bv[p] = 32'h100; end
    drive(4'b1111, cv, av, bv, c0);
    push(1, 2'd1, 32'h101, c0 + 5);
    push(2, 2'd1, 32'h102, -1);
    push(3, 2'd1, 32'h103, -1);
    push(4, 2'd1, 32'h104, -1);
    single(4, 4'd1, 32'h55, 32'h55, c1);
    wait_drain(200, "rr4");

    // Pointer is back at port 1: ports 1 and 3 together resolve as 1 then 3.
    for (int p = 0; p < 4; p++) begin cv[p] = 4'd2; av[p] = 32'h50; bv[p] = 32'(p + 1); end
    drive(4'b0101, cv, av, bv, c0);
    push(1, 2'd1, 32'h4F, c0 + 5);
    push(3, 2'd1, 32'h4D, -1);
    wait_drain(100, "rr13");

    alu_lat = 3;
    for (int i = 0; i < 8; i++) begin
      alu_err = vt[i].err;
      chk_ops = 1'b1;
      exp_cmd = vt[i].cmd; exp_op1 = vt[i].a; exp_op2 = vt[i].b;
      sc = start_cnt;
      single(vt[i].port, vt[i].cmd, vt[i].a, vt[i].b, c0);
      push(vt[i].port, vt[i].xr, vt[i].xd, (vt[i].xstart != 0) ? c0 + 6 : c0 + 3);
      wait_drain(60, "vec");
      repeat (3) @(negedge c_clk);
      chk("start_count", 64'(start_cnt - sc), 64'(vt[i].xstart));
    end
    chk_ops = 1'b0;
    alu_err = 1'b0;

    // Reset while port 1 is in flight and ports 2 and 3 are pending.
    alu_hang = 1'b1;
    single(1, 4'd1, 32'h11, 32'h22, c0);
    for (int p = 0; p < 4; p++) begin cv[p] = 4'd1; av[p] = 32'h9; bv[p] = 32'h9; end
    drive(4'b0110, cv, av, bv, c1);
    repeat (2) @(negedge c_clk);
    chk("pre_rst_alu_cmd", alu_cmd_out, 64'd1);
    reset = 1'b0;
    @(negedge c_clk);
    #1;
    chk("mid_rst_resp", {oresp[0], oresp[1], oresp[2], oresp[3]}, 64'd0);
    chk("mid_rst_data", odata[0] | odata[1] | odata[2] | odata[3], 64'd0);
    chk("mid_rst_alu", {alu_start_out, alu_cmd_out, alu_op1_out | alu_op2_out}, 64'd0);
    @(negedge c_clk);
    reset = 1'b1;
    alu_hang = 1'b0;
    rs = resp_seen;
    sc = start_cnt;
    repeat (30) @(negedge c_clk);
    #1;
    chk("post_rst_silent", 64'(resp_seen - rs), 64'd0);
    chk("post_rst_nostart", 64'(start_cnt - sc), 64'd0);
    alu_lat = 2;
    single(2, 4'd1, 32'd5, 32'd6, c0);
    push(2, 2'd1, 32'd11, c0 + 5);
    wait_drain(40, "fresh");

    // ALU that never completes.
    alu_hang = 1'b1;
    sc = start_cnt;
    single(1, 4'd1, 32'd7, 32'd8, c0);
`ifdef CALC1_ARB_TIMEOUT_EN
    push(1, 2'd2, 32'd0, c0 + 20);
    wait_drain(60, "timeout");
    rs = resp_seen;
    poke_req++;
    repeat (5) @(negedge c_clk);
    #1;
    chk("late_done_ignored", 64'(resp_seen - rs), 64'd0);
    chk("timeout_single_start", 64'(start_cnt - sc), 64'd1);
`else
    rs = resp_seen;
    repeat (100) @(negedge c_clk);
    #1;
    chk("no_timeout_resp", 64'(resp_seen - rs), 64'd0);
    chk("hang_single_start", 64'(start_cnt - sc), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
